// File: rtl/nmcu_dispatch_ctrl.sv
// NMCU dispatch controller: fetches a NOP-terminated descriptor list,
// broadcasts descriptors/kernels/input and arbitrates NMCU writebacks.
module nmcu_dispatch_ctrl #(
  parameter int NUM_NMCUS     = 4,
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_DESCS     = 8,
  parameter int MAX_INPUT_DIM = 15
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  input  logic [ADDR_WIDTH-1:0]           desc_addr,
  input  logic [ADDR_WIDTH-1:0]           input_addr,
  input  logic [ADDR_WIDTH-1:0]           output_addr,
  input  logic [$clog2(MAX_INPUT_DIM):0]  in_width,
  input  logic [$clog2(MAX_INPUT_DIM):0]  in_height,
  output logic                            busy,
  output logic                            done,
  output logic                            desc_ovf,
  output logic                            nmcu_start,
  output logic                            bcast_valid,
  output logic [1:0]                      bcast_kind,
  output logic [DATA_WIDTH-1:0]           bcast_data,
  input  logic [NUM_NMCUS-1:0]            nmcu_wb_req,
  input  logic [NUM_NMCUS*DATA_WIDTH-1:0] nmcu_wb_data,
  output logic [NUM_NMCUS-1:0]            nmcu_wb_ack,
  input  logic [NUM_NMCUS-1:0]            nmcu_done,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_ready
);

  localparam int DW = $clog2(MAX_INPUT_DIM) + 1;
  localparam int CW = $clog2(MAX_DESCS + 1);
  localparam int IW = (MAX_DESCS > 1) ? $clog2(MAX_DESCS) : 1;
  localparam int PW = (NUM_NMCUS > 1) ? $clog2(NUM_NMCUS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DESC  = 3'd1;
  localparam logic [2:0] S_KERN  = 3'd2;
  localparam logic [2:0] S_INPUT = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] T_NOP  = 2'd0;
  localparam logic [1:0] T_CONV = 2'd1;

  logic [2:0]            state;
  logic [1:0]            d_type  [MAX_DESCS];
  logic [2:0]            d_k     [MAX_DESCS];
  logic [ADDR_WIDTH-1:0] d_kaddr [MAX_DESCS];
  logic [CW-1:0]         desc_cnt;
  logic [CW-1:0]         kidx;
  logic [5:0]            kcnt;
  logic [2*DW-1:0]       icnt;
  logic [2*DW-1:0]       in_total;
  logic [ADDR_WIDTH-1:0] wb_count;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         grant;
  logic [PW-1:0]         next_grant;
  logic [PW-1:0]         rr_idx;
  logic                  any_req;
  logic [NUM_NMCUS-1:0]  eff_req;
  logic [DATA_WIDTH-1:0] wb_slice;
  logic                  accept;
  logic                  table_end;
  logic [1:0]            cur_type;
  logic [2:0]            cur_k;
  logic [5:0]            cur_kk;
  logic [ADDR_WIDTH-1:0] cur_kaddr;

  assign busy      = (state != S_IDLE);
  assign accept    = mem_req & mem_ready;
  assign in_total  = (2*DW)'(in_width) * (2*DW)'(in_height);
  assign table_end = (kidx == CW'(MAX_DESCS));
  assign cur_type  = d_type[kidx[IW-1:0]];
  assign cur_k     = d_k[kidx[IW-1:0]];
  assign cur_kaddr = d_kaddr[kidx[IW-1:0]];
  assign cur_kk    = {3'd0, cur_k} * {3'd0, cur_k};

  // A just-acked NMCU still shows its old request for one cycle.
  always_comb begin
    eff_req    = nmcu_wb_req & ~nmcu_wb_ack;
    next_grant = rr_ptr;
    any_req    = 1'b0;
    rr_idx     = '0;
    for (int i = NUM_NMCUS - 1; i >= 0; i--) begin
      rr_idx = PW'((int'(rr_ptr) + i) % NUM_NMCUS);
      if (eff_req[rr_idx]) begin
        next_grant = rr_idx;
        any_req    = 1'b1;
      end
    end
  end

  always_comb begin
    wb_slice = '0;
    for (int n = 0; n < NUM_NMCUS; n++) begin
      if (next_grant == PW'(n))
        wb_slice = nmcu_wb_data[n*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      done        <= 1'b0;
      desc_ovf    <= 1'b0;
      nmcu_start  <= 1'b0;
      bcast_valid <= 1'b0;
      bcast_kind  <= 2'd0;
      bcast_data  <= '0;
      nmcu_wb_ack <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      desc_cnt    <= '0;
      kidx        <= '0;
      kcnt        <= '0;
      icnt        <= '0;
      wb_count    <= '0;
      rr_ptr      <= '0;
      grant       <= '0;
      for (int i = 0; i < MAX_DESCS; i++) begin
        d_type[i]  <= '0;
        d_k[i]     <= '0;
        d_kaddr[i] <= '0;
      end
    end else begin
      done        <= 1'b0;
      nmcu_start  <= 1'b0;
      bcast_valid <= 1'b0;
      nmcu_wb_ack <= '0;
      if (abort) begin
        state   <= S_IDLE;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              desc_ovf   <= 1'b0;
              nmcu_start <= 1'b1;
              mem_req    <= 1'b1;
              mem_we     <= 1'b0;
              mem_addr   <= desc_addr;
              desc_cnt   <= '0;
              wb_count   <= '0;
              rr_ptr     <= '0;
              state      <= S_DESC;
            end
          end
          S_DESC: begin
            if (accept) begin
              d_type[desc_cnt[IW-1:0]]  <= mem_rdata[1:0];
              d_k[desc_cnt[IW-1:0]]     <= mem_rdata[12:10];
              d_kaddr[desc_cnt[IW-1:0]] <=
                mem_rdata[16 +: ADDR_WIDTH];
              bcast_valid <= 1'b1;
              bcast_kind  <= 2'd0;
              bcast_data  <= mem_rdata;
              mem_addr    <= mem_addr + ADDR_WIDTH'(1);
              mem_req     <= 1'b0;
              desc_cnt    <= desc_cnt + CW'(1);
              if (mem_rdata[1:0] == T_NOP ||
                  desc_cnt == CW'(MAX_DESCS - 1)) begin
                desc_ovf <= (mem_rdata[1:0] != T_NOP);
                kidx     <= '0;
                kcnt     <= '0;
                state    <= S_KERN;
              end
            end else if (!mem_req) begin
              mem_req <= 1'b1;
            end
          end
          S_KERN: begin
            if (accept) begin
              bcast_valid <= 1'b1;
              bcast_kind  <= 2'd1;
              bcast_data  <= mem_rdata;
              mem_req     <= 1'b0;
              if (kcnt + 6'd1 == cur_kk) begin
                kcnt <= '0;
                kidx <= kidx + CW'(1);
              end else begin
                kcnt <= kcnt + 6'd1;
              end
            end else if (!mem_req) begin
              if (table_end || cur_type == T_NOP) begin
                mem_addr <= input_addr;
                icnt     <= '0;
                state    <= S_INPUT;
              end else if (cur_type == T_CONV && cur_k != 3'd0) begin
                mem_addr <= cur_kaddr + ADDR_WIDTH'(kcnt);
                mem_req  <= 1'b1;
              end else begin
                kidx <= kidx + CW'(1);
              end
            end
          end
          S_INPUT: begin
            if (accept) begin
              bcast_valid <= 1'b1;
              bcast_kind  <= 2'd2;
              bcast_data  <= mem_rdata;
              mem_addr    <= mem_addr + ADDR_WIDTH'(1);
              mem_req     <= 1'b0;
              icnt        <= icnt + (2*DW)'(1);
            end else if (!mem_req) begin
              if (icnt == in_total) state <= S_WB;
              else mem_req <= 1'b1;
            end
          end
          S_WB: begin
            if (accept) begin
              nmcu_wb_ack <= NUM_NMCUS'(1) << grant;
              wb_count    <= wb_count + ADDR_WIDTH'(1);
              rr_ptr      <= (grant == PW'(NUM_NMCUS - 1)) ?
                             '0 : grant + PW'(1);
              mem_req     <= 1'b0;
              mem_we      <= 1'b0;
            end else if (!mem_req) begin
              if (any_req) begin
                grant     <= next_grant;
                mem_addr  <= output_addr + wb_count;
                mem_wdata <= wb_slice;
                mem_we    <= 1'b1;
                mem_req   <= 1'b1;
              end else if (&nmcu_done) begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
